// File: rtl/srl_fifo_ctrl_pkg.sv
// Shared definitions for the shift-register FIFO controller.
// - Controller state encoding.
// - A ceiling-log2 helper.
// - The geometry check that the controller runs at elaboration.
// The output-register variant of the controller is selected by the
// FIFO_SRL_OUT_REG_EN macro. This package is the same with or without it.
package srl_fifo_ctrl_pkg;

   // Occupancy class of the shift-register storage.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      MID   = 2'd1,
      FULL  = 2'd2
   } fifo_state_e;

   // Smallest r such that 2**r >= value. Returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // True when the read address can reach every storage entry.
   function automatic bit depth_fits(input int addr_width, input int depth);
      return (depth >= 1) && (clog2(depth) <= addr_width);
   endfunction

endpackage

// File: rtl/srl_fifo_storage.sv
// Shift-register storage array for the SRL FIFO.
// - A write shifts din into entry 0, so entry 0 always holds the newest word.
// - dout is a combinational read of the entry selected by addr.
// - The array has no reset.
module srl_fifo_storage
   import srl_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Shift the array by one entry on every write.
   // NOTE: the data array is deliberately left unreset. Occupancy is tracked
   // by the controller, so stale words are never presented as valid. Leaving
   // the array unreset also keeps it mappable onto SRL primitives.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   // Read mux over the populated entries. Out-of-range addresses read zero.
   // NOTE: dout is given a default before the loop. Without it, any address
   // that matches no entry would leave dout unassigned and infer a latch.
   always_comb begin
      dout = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr == ADDR_WIDTH'(i)) begin
            dout = mem[i];
         end
      end
   end

endmodule

// File: rtl/srl_fifo_ctrl.sv
// Handshaked FIFO built around the shift-register storage array.
// - Qualifies producer and consumer requests.
// - Generates the storage write-enable and read address.
// - Tracks occupancy.
// - Drives registered full/empty flags.
//
// Optional build macro FIFO_SRL_OUT_REG_EN:
// - Adds an output register and a valid bit, fed by prefetch from storage.
// - Capacity becomes DEPTH+1, and write-to-visible latency becomes 2 cycles.
// - if_dout then has no combinational path from the storage array.
module srl_fifo_ctrl
   import srl_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   if_num_data_valid
);

   // Reject geometries where the read address cannot reach every entry.
   if (!depth_fits(ADDR_WIDTH, DEPTH)) begin : g_cfg_error
      $error("srl_fifo_ctrl: DEPTH=%0d must be >= 1 and <= 2**ADDR_WIDTH (ADDR_WIDTH=%0d)",
             DEPTH, ADDR_WIDTH);
   end

   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   // External handshake and storage-side push/pop.
   logic push;
   logic pop;
   logic s_push;
   logic s_pop;

   // Storage occupancy state.
   fifo_state_e           state;
   logic [ADDR_WIDTH:0]   count;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  st_empty_n;
   logic                  st_full_n;
   logic [DATA_WIDTH-1:0] stg_dout;

   // A write is accepted only while the storage has room. There is no
   // write-through into a full array, even when a pop happens in the same cycle.
   assign push      = if_write & if_write_ce & st_full_n;
   assign s_push    = push;
   assign if_full_n = st_full_n;

   srl_fifo_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_storage (
      .clk  (clk),
      .we   (s_push),
      .addr (addr),
      .din  (if_din),
      .dout (stg_dout)
   );

`ifdef FIFO_SRL_OUT_REG_EN
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;

   // The consumer pops the output register. Storage is drained into the
   // output register whenever that register is empty or being emptied.
   assign pop   = if_read & if_read_ce & out_valid;
   assign s_pop = st_empty_n & (~out_valid | pop);

   // Output-register valid bit: set on prefetch, cleared by an unrefilled pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
      end else if (s_pop) begin
         out_valid <= 1'b1;
      end else if (pop) begin
         out_valid <= 1'b0;
      end
   end

   // Output-register data: capture the storage head on prefetch.
   always_ff @(posedge clk) begin
      if (s_pop) begin
         out_data <= stg_dout;
      end
   end

   assign if_dout           = out_data;
   assign if_empty_n        = out_valid;
   assign if_num_data_valid = count + {{ADDR_WIDTH{1'b0}}, out_valid};
`else
   // The consumer pops the storage directly.
   assign pop   = if_read & if_read_ce & st_empty_n;
   assign s_pop = pop;

   assign if_dout           = stg_dout;
   assign if_empty_n        = st_empty_n;
   assign if_num_data_valid = count;
`endif

   // Occupancy FSM with registered flags. addr always points at the oldest word.
   // NOTE: every state register here is assigned with <=. All reads in this
   // block then see the pre-edge values, so the cycle behaves like a single
   // clock edge no matter how the statements are ordered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= EMPTY;
         count      <= '0;
         addr       <= '0;
         st_empty_n <= 1'b0;
         st_full_n  <= 1'b1;
      end else begin
         unique case (state)
            EMPTY: begin
               if (s_push) begin
                  count      <= CNT_ONE;
                  addr       <= '0;
                  st_empty_n <= 1'b1;
                  if (DEPTH == 1) begin
                     state     <= FULL;
                     st_full_n <= 1'b0;
                  end else begin
                     state <= MID;
                  end
               end
            end
            MID: begin
               if (s_push && !s_pop) begin
                  count <= count + CNT_ONE;
                  addr  <= addr + ADDR_ONE;
                  if (count + CNT_ONE == CNT_DEPTH) begin
                     state     <= FULL;
                     st_full_n <= 1'b0;
                  end
               end else if (s_pop && !s_push) begin
                  count <= count - CNT_ONE;
                  if (count == CNT_ONE) begin
                     state      <= EMPTY;
                     addr       <= '0;
                     st_empty_n <= 1'b0;
                  end else begin
                     addr <= addr - ADDR_ONE;
                  end
               end
               // Simultaneous push and pop leaves count and addr unchanged. The
               // shift moves the next-oldest word under the same address.
            end
            FULL: begin
               if (s_pop) begin
                  count     <= count - CNT_ONE;
                  st_full_n <= 1'b1;
                  if (DEPTH == 1) begin
                     state      <= EMPTY;
                     addr       <= '0;
                     st_empty_n <= 1'b0;
                  end else begin
                     state <= MID;
                     addr  <= addr - ADDR_ONE;
                  end
               end
            end
            default: begin
               state      <= EMPTY;
               count      <= '0;
               addr       <= '0;
               st_empty_n <= 1'b0;
               st_full_n  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Scoreboard testbench for srl_fifo_ctrl.
// Inputs are driven 1 time unit after the rising edge. The monitor samples on
// the falling edge. Accepted writes enqueue their data on exp_q. The monitor
// dequeues and compares whenever the DUT shows a completed read handshake.
// Occupancy and flags are checked against a plain counter model (default
// build). Define FIFO_SRL_OUT_REG_EN to exercise the output-register variant.
module tb_srl_fifo_ctrl;

   localparam int DW = 8;
   localparam int AW = 2;
`ifdef FIFO_SRL_OUT_REG_EN
   localparam int DEPTH = 2;
   localparam int CAP   = DEPTH + 1;
`else
   localparam int DEPTH = 4;
   localparam int CAP   = DEPTH;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_write_ce = 1'b0;
   logic          if_write = 1'b0;
   logic [DW-1:0] if_din = '0;
   logic          if_full_n;
   logic          if_read_ce = 1'b0;
   logic          if_read = 1'b0;
   logic [DW-1:0] if_dout;
   logic          if_empty_n;
   logic [AW:0]   if_num_data_valid;

   srl_fifo_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .if_write_ce       (if_write_ce),
      .if_write          (if_write),
      .if_din            (if_din),
      .if_full_n         (if_full_n),
      .if_read_ce        (if_read_ce),
      .if_read           (if_read),
      .if_dout           (if_dout),
      .if_empty_n        (if_empty_n),
      .if_num_data_valid (if_num_data_valid)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_pass = 0;
   int            m_cnt = 0;
   bit            pend_push = 1'b0;
   bit            pend_pop = 1'b0;
   bit            pend_rst = 1'b1;
   bit            mon_en = 1'b0;
   int            accepted = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // One cycle of stimulus. The model first retires the previous cycle's
   // effects, then decides whether this cycle's requests are accepted.
   task automatic step(input bit w, input bit wce, input logic [DW-1:0] d,
                       input bit r, input bit rce, input bit rst);
      @(posedge clk);
      #1;
      if (pend_rst) begin
         m_cnt = 0;
         exp_q.delete();
      end else begin
         m_cnt = m_cnt + int'(pend_push) - int'(pend_pop);
      end
`ifdef FIFO_SRL_OUT_REG_EN
      pend_push = w & wce & if_full_n;
      pend_pop  = 1'b0;
`else
      pend_push = w & wce & (m_cnt < CAP);
      pend_pop  = r & rce & (m_cnt > 0);
`endif
      pend_rst = rst;
      if (pend_push && !rst) exp_q.push_back(d);
      if_write    = w;
      if_write_ce = wce;
      if_din      = d;
      if_read     = r;
      if_read_ce  = rce;
      reset       = rst;
   endtask

   task automatic push(input logic [DW-1:0] d);
      step(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   // Monitor: scoreboard compare on every read handshake, plus occupancy flags.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (if_read && if_read_ce && if_empty_n) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               mon_exp = exp_q.pop_front();
               check("dout", 32'(if_dout), 32'(mon_exp));
            end
         end
`ifndef FIFO_SRL_OUT_REG_EN
         check("num_data_valid", 32'(if_num_data_valid), 32'(m_cnt));
         check("empty_n", 32'(if_empty_n), 32'(m_cnt > 0));
         check("full_n", 32'(if_full_n), 32'(m_cnt < CAP));
`endif
      end
   end

   initial begin
      // Reset held three cycles. Read pulses while empty must change nothing.
      do_reset(3);
      mon_en = 1'b1;
      pop();
      pop();
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle();
      check("idle_empty_n", 32'(if_empty_n), 32'd0);
      check("idle_full_n", 32'(if_full_n), 32'd1);
      check("idle_count", 32'(if_num_data_valid), 32'd0);

`ifdef FIFO_SRL_OUT_REG_EN
      // A write becomes visible two cycles later.
      push(8'h07);
      idle();
      check("oreg_not_yet_visible", 32'(if_empty_n), 32'd0);
      idle();
      check("oreg_visible", 32'(if_empty_n), 32'd1);
      pop();
      idle();
      check("oreg_drained", 32'(if_empty_n), 32'd0);

      // Capacity is DEPTH+1: three writes are accepted and the fourth is refused.
      do_reset(1);
      accepted = 0;
      for (int i = 0; i < 4; i++) begin
         push(8'hC0 + 8'(i));
         if (pend_push) accepted++;
      end
      check("oreg_full_n", 32'(if_full_n), 32'd0);
      check("oreg_count", 32'(if_num_data_valid), 32'(CAP));
      check("oreg_accepted", 32'(accepted), 32'(CAP));
      for (int i = 0; i < 5; i++) pop();
      idle();
      check("oreg_count_after_drain", 32'(if_num_data_valid), 32'd0);
`else
      // Fill to DEPTH, one extra write refused, then drain in order.
      push(8'h11);
      push(8'h22);
      push(8'h33);
      push(8'h44);
      push(8'h55);
      check("fill_full_n", 32'(if_full_n), 32'd0);
      check("fill_count", 32'(if_num_data_valid), 32'(DEPTH));
      for (int i = 0; i < 5; i++) pop();

      // Simultaneous write and read at count 2.
      push(8'hA0);
      push(8'hA1);
      step(1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0);
      idle();
      check("pushpop_count", 32'(if_num_data_valid), 32'd2);
      check("pushpop_head", 32'(if_dout), 32'hA1);
      for (int i = 0; i < 3; i++) pop();

      // Full with write and read together: only the read happens.
      for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
      step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
      idle();
      check("full_pushpop_count", 32'(if_num_data_valid), 32'd3);
      for (int i = 0; i < 4; i++) pop();

      // Write with the clock-enable low is ignored.
      step(1'b1, 1'b0, 8'h5A, 1'b0, 0, 1'b0);
      idle();
      check("ce_gated_count", 32'(if_num_data_valid), 32'd0);

      // Mid-operation reset discards contents and the concurrent write.
      push(8'h01);
      push(8'h02);
      push(8'h03);
      step(1'b1, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b1);
      idle();
      check("midreset_count", 32'(if_num_data_valid), 32'd0);
      check("midreset_empty_n", 32'(if_empty_n), 32'd0);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 800; i++) begin
         step(1'($urandom_range(0, 1)), ($urandom % 4) != 0, 8'($urandom),
              1'($urandom_range(0, 1)), ($urandom % 4) != 0, ($urandom % 60) == 0);
      end

      // Drain and confirm that every accepted word was read back.
      for (int i = 0; i < CAP + 4; i++) pop();
      idle();
      @(negedge clk);
      #1;
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      check("final_empty_n", 32'(if_empty_n), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
